instr_prefetch_buffer: RTL

// - Upstream neighbour of the IF stage: issues OBI-style instruction fetches to memory and queues the returned words.
// - Presents queued words in order to the IF stage over a valid/ready pair.
// - Redirects to a new word-aligned PC on branch_i, flushing queued data and discarding in-flight responses.

---
 rtl/prefetch_pkg.sv | 28 ++
 rtl/prefetch_fifo.sv | 59 +++++
 rtl/instr_prefetch_buffer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/prefetch_pkg.sv
// prefetch_pkg: shared types and sizing helpers for the instruction prefetch buffer.
// PREFETCH_BUS_ERR_EN adds a per-entry bus error flag to pf_entry_t.
package prefetch_pkg;

  localparam int PF_DEPTH  = 2;
  localparam int PF_ADDR_W = 32;

  // Outstanding counter must hold discarded plus live transactions.
  function automatic int out_cnt_w(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

  localparam int OUT_CNT_W = out_cnt_w(PF_DEPTH);

  typedef enum logic {
    IDLE,
    REQ
  } pf_state_e;

  typedef struct packed {
    logic [PF_ADDR_W-1:0] addr;
    logic [31:0]          rdata;
`ifdef PREFETCH_BUS_ERR_EN
    logic                 err;
`endif
  } pf_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo: small synchronous FIFO of fetched instruction entries.
// Flush has priority over push and pop in the same cycle.
module prefetch_fifo
  import prefetch_pkg::*;
#(
  parameter int  DEPTH = PF_DEPTH,
  parameter type T     = pf_entry_t,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  T              wdata,
  output T              rdata,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  T              mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer: OBI instruction fetcher feeding the IF stage.
// Define PREFETCH_BUS_ERR_EN for instr_err_i / fetch_err_o support.
module instr_prefetch_buffer
  import prefetch_pkg::*;
#(
  parameter int DEPTH  = PF_DEPTH,
  parameter int ADDR_W = PF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  output logic              fetch_valid_o,
  input  logic              fetch_ready_i,
  output logic [31:0]       fetch_rdata_o,
  output logic [ADDR_W-1:0] fetch_addr_o,
`ifdef PREFETCH_BUS_ERR_EN
  input  logic              instr_err_i,
  output logic              fetch_err_o,
`endif
  output logic              busy_o,
  output logic              instr_req_o,
  output logic [ADDR_W-1:0] instr_addr_o,
  input  logic              instr_gnt_i,
  input  logic              instr_rvalid_i,
  input  logic [31:0]       instr_rdata_i
);

  localparam int OW = out_cnt_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  pf_state_e         state, state_n;
  logic              armed;
  logic [OW-1:0]     outstanding, discard;
  logic [OW-1:0]     out_n, disc_n, live_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [ADDR_W-1:0] pend_addr, pend_addr_n;
  logic [ADDR_W-1:0] rsp_addr, target;
  logic              pend_q, pend_n;
  logic              stall, gnt, dec, keep, pop;
  logic              blocked_n, credit;
  int                cnt_n;
  logic              empty, full;
  logic [CW-1:0]     count;
  pf_entry_t         wentry, head;

  assign target = branch_addr_i & ~ADDR_W'(3);
  assign stall  = instr_req_o && !instr_gnt_i;
  assign gnt    = instr_req_o && instr_gnt_i;
  assign dec    = instr_rvalid_i && (outstanding != '0);
  assign keep   = dec && (discard == '0) && !branch_i;
  assign pop    = fetch_valid_o && fetch_ready_i;

  assign out_n  = outstanding + OW'(gnt) - OW'(dec);
  assign disc_n = branch_i ? out_n
                : discard - OW'(dec && discard != '0) + OW'(gnt && pend_q);
  assign live_n = out_n - disc_n;
  assign cnt_n  = branch_i ? 0 : int'(count) + int'(keep) - int'(pop);

  // Credit counts only words that will land in the FIFO; discards are bounded separately.
  assign credit = (armed || branch_i) && req_i && !blocked_n
               && (int'(live_n) + cnt_n < DEPTH)
               && (int'(out_n) < 2 * DEPTH)
               && (!full || pop || branch_i);

  always_comb begin
    state_n = state;
    if (!stall) state_n = credit ? REQ : IDLE;
  end

  always_comb begin
    addr_n      = addr_q;
    pend_n      = pend_q;
    pend_addr_n = pend_addr;
    unique case (1'b1)
      stall: begin
        if (branch_i) begin
          pend_n      = 1'b1;
          pend_addr_n = target;
        end
      end
      gnt: begin
        pend_n = 1'b0;
        addr_n = branch_i ? target
               : pend_q   ? pend_addr
               : addr_q + ADDR_W'(4);
      end
      default: if (branch_i) addr_n = target;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      armed       <= 1'b0;
      outstanding <= '0;
      discard     <= '0;
      addr_q      <= '0;
      pend_q      <= 1'b0;
      pend_addr   <= '0;
      rsp_addr    <= '0;
    end else begin
      state       <= state_n;
      armed       <= armed || branch_i;
      outstanding <= out_n;
      discard     <= disc_n;
      addr_q      <= addr_n;
      pend_q      <= pend_n;
      pend_addr   <= pend_addr_n;
      if (branch_i)  rsp_addr <= target;
      else if (keep) rsp_addr <= rsp_addr + ADDR_W'(4);
    end
  end

  always_comb begin
    wentry       = '0;
    wentry.addr  = rsp_addr;
    wentry.rdata = instr_rdata_i;
`ifdef PREFETCH_BUS_ERR_EN
    wentry.err   = instr_err_i;
`endif
  end

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .T     (pf_entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (keep),
    .pop   (pop),
    .flush (branch_i),
    .wdata (wentry),
    .rdata (head),
    .empty (empty),
    .full  (full),
    .count (count)
  );

`ifdef PREFETCH_BUS_ERR_EN
  logic lock_q, lock_n;

  // A faulting word stops fetching until software redirects.
  assign lock_n    = !branch_i && (lock_q || (keep && instr_err_i));
  assign blocked_n = lock_n;
  assign fetch_err_o = head.err;

  always_ff @(posedge clk) begin
    if (!rst_n) lock_q <= 1'b0;
    else        lock_q <= lock_n;
  end
`else
  assign blocked_n = 1'b0;
`endif

  assign instr_req_o   = (state == REQ);
  assign instr_addr_o  = addr_q;
  assign fetch_valid_o = !empty && !branch_i;
  assign fetch_rdata_o = head.rdata;
  assign fetch_addr_o  = head.addr;
  assign busy_o        = (outstanding != '0) || !empty;

endmodule
